// File: rtl/imem_instr_encoder.sv
// Packs RV32I field bundles into 32-bit instruction words and streams them into IMEM
// at consecutive word addresses, through a 2-entry FIFO that absorbs IMEM backpressure.
module imem_instr_encoder #(
    parameter int unsigned          ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]    BASE_ADDR = '0,
    parameter int unsigned          DEPTH     = 256
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [6:0]                   in_opcode,
    input  logic [2:0]                   in_funct3,
    input  logic [6:0]                   in_funct7,
    input  logic [4:0]                   in_rd,
    input  logic [4:0]                   in_rs1,
    input  logic [4:0]                   in_rs2,
    input  logic [31:0]                  in_imm,
    output logic                         imem_we,
    input  logic                         imem_ready,
    output logic [ADDR_W-1:0]            imem_addr,
    output logic [31:0]                  imem_wdata,
    output logic [$clog2(DEPTH+1)-1:0]   words_written,
    output logic                         done,
    output logic                         err_illegal,
    output logic [1:0]                   dbg_state
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]  push_cnt;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] fifo_addr [2];
    logic [31:0]       fifo_data [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        fifo_cnt, fifo_cnt_next;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        accept, push, pop, start_ok;

    // Handshakes: a transfer happens on a cycle where valid && ready are both high;
    // valid never waits on ready, and ready (in_ready) is a function of registered state only.
    assign in_ready = (state_q == S_RUN) && (push_cnt < DEPTH_C) && (fifo_cnt != 2'd2);
    assign accept   = in_valid && in_ready;
    assign push     = accept && enc_legal;
    assign imem_we  = (fifo_cnt != 2'd0);
    assign pop      = imem_we && imem_ready;
    assign start_ok = start && (state_q != S_RUN);

    assign fifo_cnt_next = fifo_cnt + {1'b0, push} - {1'b0, pop};

    assign imem_addr  = imem_we ? fifo_addr[rd_ptr] : next_addr;
    assign imem_wdata = imem_we ? fifo_data[rd_ptr] : 32'd0;
    assign done       = (state_q == S_DONE);
    assign dbg_state  = state_q;

    always_comb begin
        enc_word  = 32'd0;
        enc_legal = 1'b1;
        case (in_opcode)
            7'h03, 7'h13, 7'h67:
                enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            7'h23:
                enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            7'h33:
                enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            7'h63: begin
                enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                             in_imm[4:1], in_imm[11], in_opcode};
                enc_legal = ~in_imm[0];
            end
            7'h37, 7'h17:
                enc_word = {in_imm[31:12], in_rd, in_opcode};
            7'h6F: begin
                enc_word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                enc_legal = ~in_imm[0];
            end
            default:
                enc_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // The session closes on the same edge that drains the last word.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN:  if ((push_cnt == DEPTH_C) && (fifo_cnt_next == 2'd0)) state_d = S_DONE;
            S_DONE: if (start) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            push_cnt      <= '0;
            next_addr     <= BASE_ADDR;
            words_written <= '0;
            err_illegal   <= 1'b0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            fifo_cnt      <= 2'd0;
            fifo_addr[0]  <= '0;
            fifo_addr[1]  <= '0;
            fifo_data[0]  <= '0;
            fifo_data[1]  <= '0;
        end else begin
            if (push) begin
                fifo_addr[wr_ptr] <= next_addr;
                fifo_data[wr_ptr] <= enc_word;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt_next;

            if (start_ok) begin
                push_cnt      <= '0;
                next_addr     <= BASE_ADDR;
                words_written <= '0;
                err_illegal   <= 1'b0;
            end else begin
                if (push) begin
                    push_cnt  <= push_cnt + CNT_W'(1);
                    next_addr <= next_addr + ADDR_W'(4);
                end
                if (accept && !enc_legal) err_illegal <= 1'b1;
                if (pop) words_written <= words_written + CNT_W'(1);
            end
        end
    end

endmodule
